// File: rtl/sn74ls57_seq.sv
// rtl/sn74ls57_seq.sv - clear/pulse/check sequencer for an sn74ls57 divider
// Optional self-check logic is built only when SN74LS57_SEQ_CHECK_EN is defined.
module sn74ls57_seq #(
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 4,
    parameter int CLR_W   = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic [7:0] ncyc,
    input  logic       qa,
    input  logic       qb,
    input  logic       qc,
    output logic       dclka,
    output logic       dclkb,
    output logic       dclr,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] pcnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_RECOV, S_CHK0, S_PHI, S_PLO, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic [3:0] k_q, k_d;
    logic [8:0] per_q, per_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] ncyc_q, ncyc_d;
    logic       err_q, err_d;
    logic       dclka_q, dclka_d;
    logic       dclkb_q, dclkb_d;
    logic       dclr_q, dclr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] ratio;
    logic [8:0] target;
    logic       zero_bad;
    logic       lvl_bad;

    always_comb begin
        ratio = 4'd10;
        case (sel_q)
            2'b00:   ratio = 4'd6;
            2'b01:   ratio = 4'd5;
            default: ratio = 4'd10;
        endcase
    end

    assign target = (ncyc_q == 8'd0) ? 9'd256 : {1'b0, ncyc_q};

`ifdef SN74LS57_SEQ_CHECK_EN
    logic [2:0] sync1_q, sync2_q;
    logic       q_sel;
    logic       exp_lvl;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {qc, qb, qa};
            sync2_q <= sync1_q;
        end
    end

    // Reference level of the selected output after pulse k of a period.
    always_comb begin
        q_sel   = sync2_q[2];
        exp_lvl = (k_q >= 4'd5) && (k_q <= 4'd9);
        case (sel_q)
            2'b00: begin
                q_sel   = sync2_q[0];
                exp_lvl = (k_q >= 4'd3) && (k_q <= 4'd5);
            end
            2'b01: begin
                q_sel   = sync2_q[1];
                exp_lvl = (k_q == 4'd4);
            end
            default: ;
        endcase
    end

    assign zero_bad = |sync2_q;
    assign lvl_bad  = (q_sel != exp_lvl);
`else
    logic unused_q;
    assign unused_q = ^{qa, qb, qc};
    assign zero_bad = 1'b0;
    assign lvl_bad  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        k_d     = k_q;
        per_d   = per_q;
        pcnt_d  = pcnt_q;
        sel_d   = sel_q;
        ncyc_d  = ncyc_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d  = sel;
                    ncyc_d = ncyc;
                    err_d  = 1'b0;
                    pcnt_d = 8'd0;
                    per_d  = 9'd0;
                    k_d    = 4'd1;
                    if (sel == 2'b11) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_CLEAR;
                        tmr_d   = 8'(CLR_W - 1);
                    end
                end
            end
            S_CLEAR: begin
                tmr_d = tmr_q - 8'd1;
                if (tmr_q == 8'd0) begin
                    state_d = S_RECOV;
                    tmr_d   = 8'(SETTLE - 1);
                end
            end
            S_RECOV: begin
                tmr_d = tmr_q - 8'd1;
                if (tmr_q == 8'd0) state_d = S_CHK0;
            end
            S_CHK0: begin
                if (zero_bad) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_PHI;
                    tmr_d   = 8'(PULSE_W - 1);
                end
            end
            S_PHI: begin
                tmr_d = tmr_q - 8'd1;
                if (tmr_q == 8'd0) begin
                    state_d = S_PLO;
                    tmr_d   = 8'(SETTLE - 1);
                end
            end
            S_PLO: begin
                tmr_d = tmr_q - 8'd1;
                if (tmr_q == 8'd0) state_d = S_CHK;
            end
            S_CHK: begin
                tmr_d = 8'(PULSE_W - 1);
                if (lvl_bad) begin
                    state_d = S_ERR;
                end else if (k_q < ratio) begin
                    k_d     = k_q + 4'd1;
                    state_d = S_PHI;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                    per_d  = per_q + 9'd1;
                    k_d    = 4'd1;
                    state_d = (per_q + 9'd1 == target) ? S_DONE : S_PHI;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERR) err_d = 1'b1;
    end

    // Drive outputs are registered off the next state so the divider clocks never glitch.
    always_comb begin
        dclka_d = (state_d == S_PHI) && (sel_d == 2'b00);
        dclkb_d = (state_d == S_PHI) && (sel_d != 2'b00);
        dclr_d  = (state_d != S_CLEAR);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE) || (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            tmr_q   <= 8'd0;
            k_q     <= 4'd1;
            per_q   <= 9'd0;
            pcnt_q  <= 8'd0;
            sel_q   <= 2'b00;
            ncyc_q  <= 8'd0;
            err_q   <= 1'b0;
            dclka_q <= 1'b0;
            dclkb_q <= 1'b0;
            dclr_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            k_q     <= k_d;
            per_q   <= per_d;
            pcnt_q  <= pcnt_d;
            sel_q   <= sel_d;
            ncyc_q  <= ncyc_d;
            err_q   <= err_d;
            dclka_q <= dclka_d;
            dclkb_q <= dclkb_d;
            dclr_q  <= dclr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dclka = dclka_q;
    assign dclkb = dclkb_q;
    assign dclr  = dclr_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign pcnt  = pcnt_q;

endmodule

// File: tb/tb_sn74ls57_seq.sv
// tb/tb_sn74ls57_seq.sv - directed-vector bench for sn74ls57_seq with a divider model
module tb_sn74ls57_seq;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic [1:0] sel;
    logic [7:0] ncyc;
    logic       qa, qb, qc;
    logic       dclka, dclkb, dclr, busy, done, err;
    logic [7:0] pcnt;

    int n_vec  = 0;
    int n_miss = 0;

    int   ca = 0;
    int   cb = 0;
    logic force_qb0 = 1'b0;

    int       pa, pb, dlow, bcyc, dcyc, guard;
    logic     err1;
    logic [9:0] qc_hist;

    sn74ls57_seq dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .sel   (sel),
        .ncyc  (ncyc),
        .qa    (qa),
        .qb    (qb),
        .qc    (qc),
        .dclka (dclka),
        .dclkb (dclkb),
        .dclr  (dclr),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .pcnt  (pcnt)
    );

    always #5 clk = ~clk;

    // Divider model: A counts mod 6 on clka falling edge, B/C share a mod-10 count on clkb.
    always @(negedge dclka or negedge dclr) begin
        if (!dclr) ca <= 0;
        else       ca <= (ca == 5) ? 0 : ca + 1;
    end
    always @(negedge dclkb or negedge dclr) begin
        if (!dclr) cb <= 0;
        else       cb <= (cb == 9) ? 0 : cb + 1;
    end
    assign qa = (ca >= 3);
    assign qb = force_qb0 ? 1'b0 : ((cb % 5) == 4);
    assign qc = (cb >= 5);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] s, input logic [7:0] n, input int restart_at);
        logic pa_prev, pb_prev;
        pa = 0; pb = 0; dlow = 0; bcyc = 0; dcyc = 0; guard = 0;
        err1 = 1'b1; qc_hist = '0;
        pa_prev = 1'b0; pb_prev = 1'b0;
        @(negedge clk);
        start = 1'b1; sel = s; ncyc = n;
        @(negedge clk);
        start = 1'b0;
        while (busy && guard < 20000) begin
            bcyc++;
            guard++;
            if (bcyc == 1) err1 = err;
            if (done) dcyc = bcyc;
            if (!dclr) dlow++;
            if (dclka && !pa_prev) pa++;
            if (dclkb && !pb_prev) begin
                if (pb < 10) qc_hist[pb] = qc;
                pb++;
            end
            pa_prev = dclka;
            pb_prev = dclkb;
            if (bcyc == restart_at) begin
                start = 1'b1; sel = 2'b01; ncyc = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("run_bounded", guard < 20000, 1);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; sel = 2'b00; ncyc = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_dclka", dclka, 0);
        check("rst_dclkb", dclkb, 0);
        check("rst_dclr", dclr, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pcnt", pcnt, 0);
        clr = 1'b0;
        @(negedge clk);

        // Reset asserted in the middle of a clka pulse
        start = 1'b1; sel = 2'b00; ncyc = 8'd1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!dclka && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("midrst_reach_phi", dclka, 1);
        clr = 1'b1;
        #1;
        check("midrst_dclka", dclka, 0);
        check("midrst_dclr", dclr, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_pcnt", pcnt, 0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        run(2'b00, 8'd1, 0);
        check("post_rst_pa", pa, 6);
        check("post_rst_done_cyc", dcyc, 52);
        check("post_rst_pcnt", pcnt, 1);
        check("post_rst_err", err, 0);

        // Channel A, two periods, with an ignored start mid-run
        run(2'b00, 8'd2, 20);
        check("a_pa", pa, 12);
        check("a_pb", pb, 0);
        check("a_done_cyc", dcyc, 94);
        check("a_busy_len", bcyc, 94);
        check("a_pcnt", pcnt, 2);
        check("a_err", err, 0);
        check("a_dclr_low", dlow, 4);

        // Channel C, one period
        run(2'b10, 8'd1, 0);
        check("c_pb", pb, 10);
        check("c_pa", pa, 0);
        check("c_qc_hist", qc_hist, 10'b1111100000);
        check("c_qc_end", qc, 0);
        check("c_done_cyc", dcyc, 80);
        check("c_pcnt", pcnt, 1);
        check("c_err", err, 0);

        // Channel B with qb stuck low
        force_qb0 = 1'b1;
        run(2'b01, 8'd3, 0);
        force_qb0 = 1'b0;
`ifdef SN74LS57_SEQ_CHECK_EN
        check("fault_err", err, 1);
        check("fault_pb", pb, 4);
        check("fault_pcnt", pcnt, 0);
        check("fault_done_cyc", dcyc, 38);
`else
        check("fault_err", err, 0);
        check("fault_pb", pb, 15);
        check("fault_pcnt", pcnt, 3);
        check("fault_done_cyc", dcyc, 115);
`endif
        run(2'b00, 8'd1, 0);
        check("clear_err_first", err1, 0);
        check("clear_err_end", err, 0);
        check("clear_pcnt", pcnt, 1);

        // Illegal select
        run(2'b11, 8'd5, 0);
        check("ill_busy_len", bcyc, 1);
        check("ill_done_cyc", dcyc, 1);
        check("ill_err", err, 1);
        check("ill_dclr_low", dlow, 0);
        check("ill_pa", pa, 0);
        check("ill_pb", pb, 0);
        check("ill_pcnt", pcnt, 0);
        repeat (3) @(negedge clk);
        check("ill_err_sticky", err, 1);

        // 256-period run on channel B, pcnt wraps
        run(2'b01, 8'd0, 0);
        check("wrap_err_first", err1, 0);
        check("wrap_pb", pb, 1280);
        check("wrap_pcnt", pcnt, 0);
        check("wrap_err", err, 0);
        check("wrap_done_cyc", dcyc, 8970);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sn74ls57_seq.md
# sn74ls57_seq

Synchronous sequencer and self-checker for an sn74ls57 frequency divider. From one system clock it clears the divider, issues a programmed number of input pulses on `clka` or `clkb`, and checks the returned `qa`/`qb`/`qc` levels against an internal reference count. It reports completion, the number of output periods counted, and any mismatch. It sits between the bench/board controller and the divider device model.

## Interface
- `PULSE_W`, 2: cycles each divider clock pulse is held high (≥1).
- `SETTLE`, 4: low/settle cycles after each pulse and after clear (≥3, covers the 2-FF synchronizer).
- `CLR_W`, 4: cycles `dclr` is held low (≥1).
- `clk` in 1: system clock, rising edge.
- `clr` in 1: reset. Asynchronous, active-high.
- `start` in 1: run request, sampled only in IDLE.
- `sel` in 2: 00 = A (÷6, `clka`→`qa`); 01 = B (÷5, `clkb`→`qb`); 10 = C (÷10, `clkb`→`qc`); 11 = illegal.
- `ncyc` in 8: output periods to run; 0 means 256.
- `qa`, `qb`, `qc` in 1 each: divider outputs, asynchronous to `clk`.
- `dclka`, `dclkb` out 1 each: divider clock drives.
- `dclr` out 1: divider clear, active-low.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: mismatch or illegal select. Sticky until the next accepted `start`.
- `pcnt` out 8: completed, verified output periods in the current or last run.

## Operation
- Reset values: `dclka`=0, `dclkb`=0, `dclr`=1, `busy`=0, `done`=0, `err`=0, `pcnt`=0, state IDLE, synchronizers 0.
- Ratio R = 6/5/10 for `sel` = 00/01/10. The pulse index k runs 1..R inside each period.
- Expected level after pulse k:
  - A: high iff k ∈ {3,4,5}.
  - B: high iff k = 4.
  - C: high iff k ∈ {5..9}.
  - k = R: all low.
- States:
  - IDLE: on `start`=1, latch `sel`/`ncyc`, clear `err` and `pcnt`, set `busy`. Go to ERR if `sel`=11, else CLEAR.
  - CLEAR: `dclr`=0 for CLR_W cycles.
  - RECOV: `dclr`=1 for SETTLE cycles.
  - CHK0: 1 cycle. All three synchronized q must be 0, else ERR.
  - PHI: selected clock high for PULSE_W cycles. Its falling edge at PLO entry is the divider's active edge.
  - PLO: selected clock low for SETTLE cycles.
  - CHK: 1 cycle. Compare the synchronized selected q with the expected level.
    - Mismatch: go to ERR.
    - k<R: k+1, go to PHI.
    - k=R: `pcnt`+1. If the period count is reached go to DONE, else k=1 and go to PHI.
  - DONE: `done`=1, `busy`=1 this cycle, then IDLE.
  - ERR: `err`=1, `done`=1 for one cycle, then IDLE. `pcnt` keeps its value.
- The unselected divider clock stays 0 for the whole run.
- `start` while `busy` is ignored. `sel`/`ncyc` changes during a run are ignored.
- `pcnt` wraps 255→0 on the 256th period. The internal period counter is 9 bits, so ncyc=0 still runs 256 periods.
- Reset mid-run returns immediately to reset values. The resulting `dclka`/`dclkb` falling edge may clock the divider; this is harmless because every run begins with CLEAR.

## Timing
- `busy` rises one cycle after the `start` sample.
- Busy duration is CLR_W + SETTLE + 1 + N·R·(PULSE_W+SETTLE+1) + 1 cycles. With defaults this is 10 + 7·N·R.
- `done` is in the last busy cycle. `busy` falls the following cycle.
- Input q levels reach CHK after a 2-FF synchronizer (2-cycle latency).
- Illegal `sel`: `busy` for 1 cycle, `done`=`err`=1 in that cycle, `dclr` never low.

## Configuration
- `SN74LS57_SEQ_CHECK_EN` defined:
  - Synchronizers, CHK0 and CHK comparisons, and the ERR path on mismatch are present.
- Not defined:
  - `qa`/`qb`/`qc` are ignored and no synchronizers are built.
  - CHK0/CHK always pass, and `pcnt` counts periods unconditionally.
  - `err` is set only by `sel`=11.
  - Cycle timing is identical.

## Test plan
- Reset: assert `clr` mid-PHI → same cycle `dclka`=0, `dclr`=1, `busy`/`done`/`err`=0, `pcnt`=0. A following `sel`=00, `ncyc`=1 run passes.
- Channel A (with conforming sn74ls57 model): `sel`=00, `ncyc`=2 → 12 `dclka` pulses, 0 `dclkb` pulses, `done` at busy cycle 94, `pcnt`=2, `err`=0. A second `start` at busy cycle 20 is ignored.
- Channel C: `sel`=10, `ncyc`=1 → 10 `dclkb` pulses, `qc` high for k = 5..9, `done` at busy cycle 80, `pcnt`=1, `err`=0.
- Fault: `sel`=01, `ncyc`=3, `qb` forced 0 → `err`=1 at CHK of pulse 4, exactly 4 `dclkb` pulses, `pcnt`=0. `err` clears on the next `start`.
- Illegal select: `sel`=11 → `done`=`err`=1 one cycle after `start`, no `dclr`/`dclka`/`dclkb` activity.
- Wrap: `sel`=01, `ncyc`=0 (macro undefined) → 1280 `dclkb` pulses, `pcnt`=0 at `done`, `err`=0.
